// File: rtl/spi_adc_if.sv
// SPI pins between the ADC master and the responder. The master drives SCK, CS_n and MOSI;
// the responder drives MISO plus an output enable for the pad or tri-state logic.
interface spi_adc_if;
    logic spi_sck;
    logic spi_cs_n;
    logic spi_mosi;
    logic spi_miso;
    logic spi_miso_oe;

    modport master (
        output spi_sck,
        output spi_cs_n,
        output spi_mosi,
        input  spi_miso,
        input  spi_miso_oe
    );

    modport slave (
        input  spi_sck,
        input  spi_cs_n,
        input  spi_mosi,
        output spi_miso,
        output spi_miso_oe
    );
endinterface

// File: rtl/spi_adc_responder.sv
// MCP3204-style SPI ADC responder: oversampled SPI pins, 4 channels, single-ended or
// differential conversions with saturation at zero, frame counting and abort detection.
module spi_adc_responder #(
    parameter int DATA_W      = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    spi_adc_if.slave          spi,
    input  logic [DATA_W-1:0] ch0,
    input  logic [DATA_W-1:0] ch1,
    input  logic [DATA_W-1:0] ch2,
    input  logic [DATA_W-1:0] ch3,
    output logic              conv_done,
    output logic [1:0]        last_ch,
    output logic              frame_err,
    output logic [7:0]        frame_cnt,
    output logic [2:0]        state_dbg
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DATA_W);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_START = 3'd1,
        CMD        = 3'd2,
        SAMPLE     = 3'd3,
        NULLB      = 3'd4,
        DATA       = 3'd5,
        TRAIL      = 3'd6
    } state_t;

    logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
    logic sck_q, cs_q;
    logic sck_s, cs_s, mosi_s;
    logic sck_rise, sck_fall, cs_rise, cs_fall;

    state_t            state, state_n;
    logic              armed, armed_n;
    logic              sgl, sgl_n;
    logic              d1, d1_n;
    logic              d0, d0_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic              miso, miso_n;
    logic              miso_oe, miso_oe_n;
    logic              conv_done_n, frame_err_n;
    logic [1:0]        last_ch_n;
    logic [7:0]        frame_cnt_n;

    logic [1:0]        sel_now;
    logic [DATA_W-1:0] pos, neg, result;
    logic [DATA_W:0]   diff;

    // Sync chains clear to 0 so a CS_n held low through reset never arms the block.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sck_sync  <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
            sck_q     <= 1'b0;
            cs_q      <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi.spi_sck};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi.spi_cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.spi_mosi};
            sck_q     <= sck_sync[SYNC_STAGES-1];
            cs_q      <= cs_sync[SYNC_STAGES-1];
        end
    end

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_q;
    assign sck_fall = ~sck_s & sck_q;
    assign cs_rise  = cs_s & ~cs_q;
    assign cs_fall  = ~cs_s & cs_q;

    // Conversion result, evaluated at r4 when D0 is on MOSI. The positive operand of each
    // differential pair is also the single-ended channel for the same select code.
    always_comb begin
        sel_now = {d1, mosi_s};
        case (sel_now)
            2'b00:   begin pos = ch0; neg = ch1; end
            2'b01:   begin pos = ch1; neg = ch0; end
            2'b10:   begin pos = ch2; neg = ch3; end
            default: begin pos = ch3; neg = ch2; end
        endcase
        diff = {1'b0, pos} - {1'b0, neg};
        if (sgl)
            result = pos;
        else if (diff[DATA_W])
            result = '0;
        else
            result = diff[DATA_W-1:0];
    end

    always_comb begin
        state_n     = state;
        armed_n     = armed | cs_s;
        sgl_n       = sgl;
        d1_n        = d1;
        d0_n        = d0;
        cnt_n       = cnt;
        shreg_n     = shreg;
        miso_n      = miso;
        miso_oe_n   = miso_oe;
        conv_done_n = 1'b0;
        frame_err_n = 1'b0;
        last_ch_n   = last_ch;
        frame_cnt_n = frame_cnt;

        // A CS_n rise overrides any SCK edge seen in the same clock.
        if (cs_rise) begin
            state_n   = IDLE;
            miso_n    = 1'b0;
            miso_oe_n = 1'b0;
            armed_n   = 1'b1;
            if (state == CMD || state == SAMPLE || state == NULLB || state == DATA)
                frame_err_n = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (cs_fall && armed)
                        state_n = WAIT_START;
                end
                WAIT_START: begin
                    if (sck_rise && mosi_s) begin
                        state_n = CMD;
                        cnt_n   = '0;
                    end
                end
                CMD: begin
                    if (sck_rise) begin
                        cnt_n = cnt + CNT_W'(1);
                        case (cnt)
                            CNT_W'(0): sgl_n = mosi_s;
                            CNT_W'(2): d1_n  = mosi_s;
                            CNT_W'(3): begin
                                d0_n      = mosi_s;
                                shreg_n   = result;
                                miso_oe_n = 1'b1;
                                miso_n    = 1'b0;
                                state_n   = SAMPLE;
                            end
                            default: ;
                        endcase
                    end
                end
                SAMPLE: begin
                    if (sck_rise)
                        state_n = NULLB;
                end
                NULLB: begin
                    if (sck_fall) begin
                        miso_n  = 1'b0;
                        cnt_n   = '0;
                        state_n = DATA;
                    end
                end
                DATA: begin
                    if (sck_fall && cnt != CNT_DONE) begin
                        miso_n  = shreg[DATA_W-1];
                        shreg_n = {shreg[DATA_W-2:0], 1'b0};
                        cnt_n   = cnt + CNT_W'(1);
                    end else if (sck_rise && cnt == CNT_DONE) begin
                        conv_done_n = 1'b1;
                        last_ch_n   = {d1, d0};
                        frame_cnt_n = frame_cnt + 8'd1;
                        miso_n      = 1'b0;
                        state_n     = TRAIL;
                    end
                end
                TRAIL: begin
                    miso_n = 1'b0;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            armed     <= 1'b0;
            sgl       <= 1'b0;
            d1        <= 1'b0;
            d0        <= 1'b0;
            cnt       <= '0;
            shreg     <= '0;
            miso      <= 1'b0;
            miso_oe   <= 1'b0;
            conv_done <= 1'b0;
            frame_err <= 1'b0;
            last_ch   <= 2'd0;
            frame_cnt <= 8'd0;
        end else begin
            state     <= state_n;
            armed     <= armed_n;
            sgl       <= sgl_n;
            d1        <= d1_n;
            d0        <= d0_n;
            cnt       <= cnt_n;
            shreg     <= shreg_n;
            miso      <= miso_n;
            miso_oe   <= miso_oe_n;
            conv_done <= conv_done_n;
            frame_err <= frame_err_n;
            last_ch   <= last_ch_n;
            frame_cnt <= frame_cnt_n;
        end
    end

    assign spi.spi_miso    = miso;
    assign spi.spi_miso_oe = miso_oe;
    assign state_dbg       = state;

endmodule

// File: tb/tb_spi_adc_responder.sv
// Bench for spi_adc_responder: drives SPI frames as a master would and checks the bits it
// reads back against a channel-arithmetic reference model.
module tb_spi_adc_responder;

    localparam int H   = 5;   // SCK half period in clk cycles
    localparam int SYN = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] chv [4];
    logic        conv_done, frame_err;
    logic [1:0]  last_ch;
    logic [7:0]  frame_cnt;
    logic [2:0]  state_dbg;

    spi_adc_if bus ();

    spi_adc_responder #(.DATA_W(12), .SYNC_STAGES(SYN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .spi       (bus),
        .ch0       (chv[0]),
        .ch1       (chv[1]),
        .ch2       (chv[2]),
        .ch3       (chv[3]),
        .conv_done (conv_done),
        .last_ch   (last_ch),
        .frame_err (frame_err),
        .frame_cnt (frame_cnt),
        .state_dbg (state_dbg)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int exp_frames = 0;
    int done_pulses = 0, err_pulses = 0, both_pulses = 0, oe_high_clks = 0;
    logic [12:0] exp_q [$];

    always @(posedge clk) begin
        #1;
        if (conv_done) done_pulses++;
        if (frame_err) err_pulses++;
        if (conv_done && frame_err) both_pulses++;
        if (bus.spi_miso_oe) oe_high_clks++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: single-ended reads the channel; differential subtracts the pair partner and
    // clamps negative differences to zero.
    function automatic logic [11:0] model_result(input logic sgl, input logic [1:0] sel);
        int a, b;
        a = int'(chv[sel]);
        b = int'(chv[sel ^ 2'b01]);
        if (sgl) return chv[sel];
        if (a < b) return 12'd0;
        return 12'(a - b);
    endfunction

    function automatic logic cmd_bit(input int k, input logic sgl, input logic [2:0] d);
        case (k)
            0:       return 1'b1;
            1:       return sgl;
            2:       return d[2];
            3:       return d[1];
            4:       return d[0];
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic sck_cycle(input logic b, output logic sampled);
        bus.spi_mosi = b;
        repeat (H) @(negedge clk);
        sampled = bus.spi_miso;
        bus.spi_sck = 1'b1;
        repeat (H) @(negedge clk);
        bus.spi_sck = 1'b0;
    endtask

    // rd[12] is the null bit sampled at r6, rd[11:0] are B11..B0 sampled at r7..r18.
    task automatic do_frame(input logic sgl, input logic [2:0] d, input int lead,
                            input int n_rise, input bit change_ch2, output logic [12:0] rd);
        logic s;
        rd = '0;
        bus.spi_cs_n = 1'b0;
        repeat (H) @(negedge clk);
        for (int i = 0; i < lead; i++) sck_cycle(1'b0, s);
        for (int k = 0; k < n_rise; k++) begin
            sck_cycle(cmd_bit(k, sgl, d), s);
            if (k >= 6 && k <= 18) rd[18-k] = s;
            if (change_ch2 && k == 4) chv[2] = 12'h123;
        end
        bus.spi_cs_n = 1'b1;
        bus.spi_mosi = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.spi_cs_n = 1'b1;
        bus.spi_sck = 1'b0;
        bus.spi_mosi = 1'b0;
        for (int i = 0; i < 4; i++) chv[i] = 12'($urandom_range(0, 4095));
        repeat (4) @(negedge clk);
        checks++; if (bus.spi_miso !== 1'b0) $display("FAIL reset_miso: got %b want 0", bus.spi_miso); else passed++;
        checks++; if (bus.spi_miso_oe !== 1'b0) $display("FAIL reset_oe: got %b want 0", bus.spi_miso_oe); else passed++;
        checks++; if (conv_done !== 1'b0) $display("FAIL reset_conv_done: got %b want 0", conv_done); else passed++;
        checks++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b want 0", frame_err); else passed++;
        checks++; if (last_ch !== 2'd0) $display("FAIL reset_last_ch: got %0d want 0", last_ch); else passed++;
        checks++; if (frame_cnt !== 8'd0) $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); else passed++;
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_single_ended;
        logic [12:0] rd;
        int dn0, e0;
        chv[2] = 12'hABC;
        dn0 = done_pulses; e0 = err_pulses;
        do_frame(1'b1, 3'b010, 0, 24, 1'b0, rd);
        exp_frames++;
        checks++; if (rd !== 13'h0ABC) $display("FAIL t1_read: got %h want 0abc", rd); else passed++;
        checks++; if (done_pulses - dn0 !== 1) $display("FAIL t1_conv_done: got %0d pulses want 1", done_pulses - dn0); else passed++;
        checks++; if (err_pulses - e0 !== 0) $display("FAIL t1_frame_err: got %0d pulses want 0", err_pulses - e0); else passed++;
        checks++; if (last_ch !== 2'd2) $display("FAIL t1_last_ch: got %0d want 2", last_ch); else passed++;
        checks++; if (frame_cnt !== 8'd1) $display("FAIL t1_frame_cnt: got %0d want 1", frame_cnt); else passed++;
        checks++; if (bus.spi_miso_oe !== 1'b0) $display("FAIL t1_oe_after: got %b want 0", bus.spi_miso_oe); else passed++;
    endtask

    task automatic test_differential;
        logic [12:0] rd;
        chv[0] = 12'd100; chv[1] = 12'd40;
        do_frame(1'b0, 3'b000, 0, 20, 1'b0, rd);
        exp_frames++;
        checks++; if (rd !== {1'b0, 12'd60}) $display("FAIL t2_diff_pos: got %0d want 60", rd); else passed++;
        do_frame(1'b0, 3'b001, 0, 20, 1'b0, rd);
        exp_frames++;
        checks++; if (rd !== 13'd0) $display("FAIL t2_diff_sat: got %0d want 0", rd); else passed++;
        checks++; if (last_ch !== 2'd1) $display("FAIL t2_last_ch: got %0d want 1", last_ch); else passed++;
        checks++; if (frame_cnt !== 8'(exp_frames)) $display("FAIL t2_frame_cnt: got %0d want %0d", frame_cnt, 8'(exp_frames)); else passed++;
    endtask

    task automatic test_leading_zeros_snapshot;
        logic [12:0] rd;
        chv[2] = 12'hABC;
        do_frame(1'b1, 3'b010, 3, 24, 1'b1, rd);
        exp_frames++;
        checks++; if (rd !== 13'h0ABC) $display("FAIL t3_snapshot: got %h want 0abc", rd); else passed++;
        checks++; if (chv[2] !== 12'h123) $display("FAIL t3_ch2_changed: got %h want 123", chv[2]); else passed++;
    endtask

    task automatic test_abort;
        logic s;
        logic [12:0] rd, exp;
        int dn0, e0;
        dn0 = done_pulses; e0 = err_pulses;
        bus.spi_cs_n = 1'b0;
        repeat (H) @(negedge clk);
        for (int k = 0; k <= 10; k++) sck_cycle(cmd_bit(k, 1'b1, 3'b011), s);
        repeat (H) @(negedge clk);
        checks++; if (bus.spi_miso_oe !== 1'b1) $display("FAIL t4_oe_mid: got %b want 1", bus.spi_miso_oe); else passed++;
        bus.spi_cs_n = 1'b1;
        repeat (SYN + 2) @(negedge clk);
        checks++; if (bus.spi_miso_oe !== 1'b0) $display("FAIL t4_oe_release: got %b want 0", bus.spi_miso_oe); else passed++;
        repeat (4) @(negedge clk);
        checks++; if (err_pulses - e0 !== 1) $display("FAIL t4_frame_err: got %0d pulses want 1", err_pulses - e0); else passed++;
        checks++; if (done_pulses - dn0 !== 0) $display("FAIL t4_no_done: got %0d pulses want 0", done_pulses - dn0); else passed++;
        checks++; if (frame_cnt !== 8'(exp_frames)) $display("FAIL t4_frame_cnt: got %0d want %0d", frame_cnt, 8'(exp_frames)); else passed++;
        chv[3] = 12'h5A5;
        exp = {1'b0, model_result(1'b1, 2'b11)};
        do_frame(1'b1, 3'b011, 0, 22, 1'b0, rd);
        exp_frames++;
        checks++; if (rd !== exp) $display("FAIL t4_next_frame: got %h want %h", rd, exp); else passed++;
        checks++; if (frame_cnt !== 8'(exp_frames)) $display("FAIL t4_next_cnt: got %0d want %0d", frame_cnt, 8'(exp_frames)); else passed++;
    endtask

    task automatic test_reset_mid_frame;
        logic s;
        logic [12:0] rd, exp;
        int dn0, e0, oe0;
        bus.spi_cs_n = 1'b0;
        repeat (H) @(negedge clk);
        for (int k = 0; k < 8; k++) sck_cycle(cmd_bit(k, 1'b1, 3'b001), s);
        rst_n = 1'b0;
        sck_cycle(1'b1, s);
        rst_n = 1'b1;
        exp_frames = 0;
        @(negedge clk);
        dn0 = done_pulses; e0 = err_pulses; oe0 = oe_high_clks;
        for (int k = 0; k < 16; k++) sck_cycle((k % 3 == 0) ? 1'b1 : 1'(($urandom_range(0, 1))), s);
        checks++; if (oe_high_clks - oe0 !== 0) $display("FAIL t5_no_oe: got %0d clks driven want 0", oe_high_clks - oe0); else passed++;
        checks++; if (done_pulses - dn0 !== 0) $display("FAIL t5_no_done: got %0d pulses want 0", done_pulses - dn0); else passed++;
        checks++; if (err_pulses - e0 !== 0) $display("FAIL t5_no_err: got %0d pulses want 0", err_pulses - e0); else passed++;
        checks++; if (frame_cnt !== 8'd0) $display("FAIL t5_cnt_cleared: got %0d want 0", frame_cnt); else passed++;
        bus.spi_cs_n = 1'b1;
        repeat (8) @(negedge clk);
        chv[1] = 12'($urandom_range(0, 4095));
        exp = {1'b0, model_result(1'b1, 2'b01)};
        do_frame(1'b1, 3'b001, 0, 20, 1'b0, rd);
        exp_frames++;
        checks++; if (rd !== exp) $display("FAIL t5_next_frame: got %h want %h", rd, exp); else passed++;
        checks++; if (frame_cnt !== 8'd1) $display("FAIL t5_next_cnt: got %0d want 1", frame_cnt); else passed++;
    endtask

    task automatic test_coincident_cs;
        logic s;
        int e0;
        e0 = err_pulses;
        chv[3] = 12'hFFF;
        bus.spi_cs_n = 1'b0;
        repeat (H) @(negedge clk);
        for (int k = 0; k < 12; k++) sck_cycle(cmd_bit(k, 1'b1, 3'b011), s);
        bus.spi_mosi = 1'b0;
        repeat (H) @(negedge clk);
        s = bus.spi_miso;
        bus.spi_sck = 1'b1;
        repeat (H) @(negedge clk);
        bus.spi_sck = 1'b0;
        bus.spi_cs_n = 1'b1;
        checks++; if (s !== 1'b1) $display("FAIL t6c_bit_b6: got %b want 1", s); else passed++;
        repeat (6) @(negedge clk);
        checks++; if (bus.spi_miso !== 1'b0) $display("FAIL t6c_miso: got %b want 0", bus.spi_miso); else passed++;
        checks++; if (bus.spi_miso_oe !== 1'b0) $display("FAIL t6c_oe: got %b want 0", bus.spi_miso_oe); else passed++;
        checks++; if (err_pulses - e0 !== 1) $display("FAIL t6c_frame_err: got %0d pulses want 1", err_pulses - e0); else passed++;
        checks++; if (frame_cnt !== 8'(exp_frames)) $display("FAIL t6c_frame_cnt: got %0d want %0d", frame_cnt, 8'(exp_frames)); else passed++;
    endtask

    task automatic test_random_frames;
        logic [12:0] rd, exp;
        logic sgl;
        logic [2:0] d;
        int dn0;
        for (int i = 0; i < 20; i++) begin
            for (int c = 0; c < 4; c++) chv[c] = 12'($urandom_range(0, 4095));
            sgl = 1'($urandom_range(0, 1));
            d = 3'($urandom_range(0, 7));
            exp_q.push_back({1'b0, model_result(sgl, d[1:0])});
            dn0 = done_pulses;
            do_frame(sgl, d, $urandom_range(0, 2), $urandom_range(19, 24), 1'b0, rd);
            exp_frames++;
            exp = exp_q.pop_front();
            checks++; if (rd !== exp) $display("FAIL rand_read[%0d]: got %h want %h", i, rd, exp); else passed++;
            checks++; if (last_ch !== d[1:0]) $display("FAIL rand_last_ch[%0d]: got %0d want %0d", i, last_ch, d[1:0]); else passed++;
            checks++; if (done_pulses - dn0 !== 1) $display("FAIL rand_done[%0d]: got %0d want 1", i, done_pulses - dn0); else passed++;
        end
        checks++; if (frame_cnt !== 8'(exp_frames)) $display("FAIL rand_frame_cnt: got %0d want %0d", frame_cnt, 8'(exp_frames)); else passed++;
    endtask

    task automatic test_back_to_back;
        logic [12:0] rd, exp;
        logic sgl;
        logic [2:0] d;
        for (int i = 0; i < 256; i++) begin
            for (int c = 0; c < 4; c++) chv[c] = 12'($urandom_range(0, 4095));
            sgl = 1'($urandom_range(0, 1));
            d = 3'($urandom_range(0, 7));
            exp_q.push_back({1'b0, model_result(sgl, d[1:0])});
            do_frame(sgl, d, 0, 19, 1'b0, rd);
            exp_frames++;
            exp = exp_q.pop_front();
            checks++; if (rd !== exp) $display("FAIL b2b_read[%0d]: got %h want %h", i, rd, exp); else passed++;
            checks++; if (frame_cnt !== 8'(exp_frames)) $display("FAIL b2b_frame_cnt[%0d]: got %0d want %0d", i, frame_cnt, 8'(exp_frames)); else passed++;
        end
        checks++; if (both_pulses !== 0) $display("FAIL done_err_overlap: got %0d clks want 0", both_pulses); else passed++;
    endtask

    initial begin
        test_reset();
        test_single_ended();
        test_differential();
        test_leading_zeros_snapshot();
        test_abort();
        test_reset_mid_frame();
        test_coincident_cs();
        test_random_frames();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
